// File: rtl/pll.sv
`timescale 1ns / 1ps
// Behavioural frequency-synthesis PLL model (simulation only): clk_o = f_ref * fbdiv / refdiv.
// Optional macro PLL_OUT_GATE_EN holds clk_o low while the loop is unlocked.
module pll #(
    parameter int unsigned REF_DEV_WIDTH = 4,
    parameter int unsigned FB_DIV_WIDTH  = 8,
    parameter int unsigned LOCK_CYCLES   = 8,
    parameter int unsigned TOL_PCT       = 1
) (
    input  logic                     clk_ref_i,
    input  logic                     rst_i,
    input  logic [REF_DEV_WIDTH-1:0] refdiv_i,
    input  logic [FB_DIV_WIDTH-1:0]  fbdiv_i,
    output logic                     clk_o,
    output logic                     locked_o
);
    localparam int unsigned CntW    = $clog2(LOCK_CYCLES + 1);
    localparam real         WdPoll  = 0.05;

    logic                     have_edge_q;
    logic                     valid_q;
    logic                     locked_q;
    logic [CntW-1:0]          cnt_q;
    logic [REF_DEV_WIDTH-1:0] ref_s_q;
    logic [FB_DIV_WIDTH-1:0]  fb_s_q;
    real                      t_last_q;
    real                      tref_q;
    real                      tout_q;
    int unsigned              epoch_q;
    int unsigned              gen_owner;
    logic                     clk_gen;
    logic                     lost;
    logic                     gen_en;

`ifdef PLL_OUT_GATE_EN
    assign gen_en = locked_q;
`else
    assign gen_en = valid_q;
`endif

    always_ff @(posedge clk_ref_i) begin
        real             now_t;
        real             tref;
        real             dev;
        real             ref_eff;
        real             fb_eff;
        logic            stable;
        logic [CntW-1:0] cnt_n;
        now_t   = $realtime;
        tref    = now_t - t_last_q;
        dev     = (tref > tref_q) ? (tref - tref_q) : (tref_q - tref);
        ref_eff = (refdiv_i == '0) ? 1.0 : real'(refdiv_i);
        fb_eff  = (fbdiv_i == '0) ? 1.0 : real'(fbdiv_i);
        stable  = (refdiv_i == ref_s_q) && (fbdiv_i == fb_s_q) &&
                  (!valid_q || dev <= tref_q * real'(TOL_PCT) / 100.0);
        if (!stable) begin
            cnt_n = '0;
        end else if (cnt_q == CntW'(LOCK_CYCLES)) begin
            cnt_n = cnt_q;
        end else begin
            cnt_n = cnt_q + 1'b1;
        end

        if (rst_i) begin
            have_edge_q <= 1'b0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            cnt_q       <= '0;
            ref_s_q     <= '0;
            fb_s_q      <= '0;
            tref_q      <= 0.0;
            epoch_q     <= epoch_q + 1;
        end else if (!have_edge_q || (valid_q && tref > 4.0 * tref_q)) begin
            // First edge after reset or after reference loss: timestamp only.
            have_edge_q <= 1'b1;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            cnt_q       <= '0;
            ref_s_q     <= refdiv_i;
            fb_s_q      <= fbdiv_i;
            t_last_q    <= now_t;
            if (valid_q) epoch_q <= epoch_q + 1;
        end else begin
            valid_q  <= 1'b1;
            cnt_q    <= cnt_n;
            locked_q <= (cnt_n == CntW'(LOCK_CYCLES));
            ref_s_q  <= refdiv_i;
            fb_s_q   <= fbdiv_i;
            t_last_q <= now_t;
            tref_q   <= tref;
            tout_q   <= tref * ref_eff / fb_eff;
`ifdef PLL_OUT_GATE_EN
            if ((cnt_n == CntW'(LOCK_CYCLES)) && !locked_q) epoch_q <= epoch_q + 1;
`else
            if (!valid_q) epoch_q <= epoch_q + 1;
`endif
        end
    end

    // One generator thread per epoch; stale threads lose ownership and are masked.
    task automatic run_gen(input int unsigned my_epoch);
        real half;
        while (my_epoch == epoch_q && gen_en === 1'b1) begin
            half      = tout_q / 2.0;
            gen_owner = my_epoch;
            clk_gen   = 1'b1;
            #(half);
            if (my_epoch == epoch_q) begin
                clk_gen = 1'b0;
                #(half);
            end
        end
    endtask

    always @(epoch_q) begin
        if (gen_en === 1'b1) begin
            fork
                run_gen(epoch_q);
            join_none
        end
    end

    always begin
        #(WdPoll);
        lost = (valid_q === 1'b1) && (($realtime - t_last_q) > 4.0 * tref_q);
    end

    assign clk_o    = clk_gen & (gen_owner == epoch_q) & ~lost;
    assign locked_o = locked_q & ~lost;

endmodule

// File: tb/tb_pll.sv
`timescale 1ns / 1ps
// Self-checking bench for pll: table of divider settings, lock-sequence scoreboard,
// clk_o period/phase measurement, reference-loss and mid-run reset sequences.
module tb_pll;
    localparam int unsigned LockCycles = 8;

    logic       clk_ref = 1'b0;
    logic       rst;
    logic [3:0] refdiv;
    logic [7:0] fbdiv;
    logic       clk_o;
    logic       locked;
    logic       ref_en = 1'b1;

    int tests = 0;
    int fails = 0;

    pll dut (
        .clk_ref_i (clk_ref),
        .rst_i     (rst),
        .refdiv_i  (refdiv),
        .fbdiv_i   (fbdiv),
        .clk_o     (clk_o),
        .locked_o  (locked)
    );

    // 10 ns reference; when disabled it finishes a high phase and then idles low.
    always begin
        #5;
        if (ref_en || clk_ref) clk_ref = ~clk_ref;
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_real(input string name, input real act, input real exp, input real tol);
        real d;
        tests++;
        d = (act > exp) ? act - exp : exp - act;
        if (d > tol) begin
            fails++;
            $display("FAIL %s: got %f, expected %f at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard of expected locked_o values, one per reference rising edge.
    bit exp_q[$];
    bit prev1 = 1'b1;
    bit prev2 = 1'b1;

    always @(posedge clk_ref) begin
        bit e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_bit("locked_edge", locked, e);
`ifdef PLL_OUT_GATE_EN
            if (!e && !prev1 && !prev2) check_bit("gated_clk_low", clk_o, 1'b0);
`endif
            prev2 = prev1;
            prev1 = e;
        end
    end

    task automatic push_lock_seq();
        for (int k = 0; k < LockCycles; k++) exp_q.push_back(1'b0);
        for (int k = 0; k < 3; k++) exp_q.push_back(1'b1);
    endtask

    task automatic wait_sb_empty(input int budget);
        for (int n = 0; n < budget && exp_q.size() > 0; n++) @(posedge clk_ref);
        #2;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL sb_timeout: %0d entries left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // clk_o edge monitor.
    real t_rise = -1.0;
    real t_fall = -1.0;
    real per_min = 1.0e9;
    real per_max = 0.0;
    real hi_min = 1.0e9;
    real lo_min = 1.0e9;

    always @(posedge clk_o) begin
        real p;
        if (t_rise >= 0.0) begin
            p = $realtime - t_rise;
            if (p < per_min) per_min = p;
            if (p > per_max) per_max = p;
        end
        if (t_fall >= 0.0 && ($realtime - t_fall) < lo_min) lo_min = $realtime - t_fall;
        t_rise = $realtime;
    end

    always @(negedge clk_o) begin
        if (t_rise >= 0.0 && ($realtime - t_rise) < hi_min) hi_min = $realtime - t_rise;
        t_fall = $realtime;
    end

    task automatic measure_period(input string name, input real exp);
        per_min = 1.0e9;
        per_max = 0.0;
        #60;
        check_real({name, "_min"}, per_min, exp, 0.01);
        check_real({name, "_max"}, per_max, exp, 0.01);
    endtask

    typedef struct {
        logic [3:0] refdiv;
        logic [7:0] fbdiv;
        real        period;
    } vec_t;

    vec_t vecs[6];

    initial begin
        real t0;
        bool_dummy: begin end
        vecs[0] = '{refdiv: 4'd0, fbdiv: 8'd0, period: 10.0};
        vecs[1] = '{refdiv: 4'd2, fbdiv: 8'd0, period: 20.0};
        vecs[2] = '{refdiv: 4'd2, fbdiv: 8'd2, period: 10.0};
        vecs[3] = '{refdiv: 4'd2, fbdiv: 8'd4, period: 5.0};
        vecs[4] = '{refdiv: 4'd1, fbdiv: 8'd4, period: 2.5};
        vecs[5] = '{refdiv: 4'd0, fbdiv: 8'd3, period: 10.0 / 3.0};

        rst    = 1'b1;
        refdiv = vecs[0].refdiv;
        fbdiv  = vecs[0].fbdiv;

        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                @(posedge clk_ref);
                #1;
                check_bit("reset_locked", locked, 1'b0);
                check_bit("reset_clk", clk_o, 1'b0);
                @(negedge clk_ref);
                rst = 1'b0;
                push_lock_seq();
            end else begin
                @(negedge clk_ref);
                refdiv = vecs[i].refdiv;
                fbdiv  = vecs[i].fbdiv;
                push_lock_seq();
            end
            wait_sb_empty(40);
            measure_period($sformatf("period_v%0d", i), vecs[i].period);
            if (i == 0) begin
                hi_min = 1.0e9;
                lo_min = 1.0e9;
            end
        end
        // Shortest legal phase across all later changes is half of 2.5 ns.
        tests++;
        if (hi_min < 1.249 || lo_min < 1.249) begin
            fails++;
            $display("FAIL min_phase: high %f low %f, expected >= 1.25", hi_min, lo_min);
        end

        // Reference loss while locked.
        @(posedge clk_ref);
        t0 = $realtime;
        #1;
        ref_en = 1'b0;
        #40;
        check_bit("loss_locked", locked, 1'b0);
        check_bit("loss_clk", clk_o, 1'b0);
        #5;
        check_bit("loss_clk_late", clk_o, 1'b0);
        #6;
        ref_en = 1'b1;
        push_lock_seq();
        @(posedge clk_ref);
        #2;
        check_bit("recover_clk_stopped", clk_o, 1'b0);
        wait_sb_empty(40);
        measure_period("period_recover", 10.0 / 3.0);

        // Mid-run reset with a simultaneous divider change: reset wins.
        @(negedge clk_ref);
        rst    = 1'b1;
        refdiv = 4'd1;
        fbdiv  = 8'd2;
        exp_q.push_back(1'b0);
        @(posedge clk_ref);
        #0.5;
        check_bit("midreset_clk", clk_o, 1'b0);
        @(negedge clk_ref);
        rst = 1'b0;
        push_lock_seq();
        wait_sb_empty(40);
        measure_period("period_after_reset", 5.0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
